// File: rtl/can_pkg.sv
// Shared definitions for the CAN frame receiver: FSM states, field widths,
// frame constants, error codes and the serial CRC-15 step function.
package can_pkg;

    typedef enum logic [3:0] {
        ST_INTEG = 4'd0,
        ST_IDLE  = 4'd1,
        ST_HDR   = 4'd2,
        ST_DATA  = 4'd3,
        ST_CRC   = 4'd4,
        ST_DELIM = 4'd5,
        ST_EOF   = 4'd6,
        ST_DONE  = 4'd7,
        ST_ERROR = 4'd8
    } can_state_t;

    localparam int ID_W   = 11;
    localparam int CTRL_W = 2;
    localparam int DLC_W  = 4;
    localparam int CRC_W  = 15;

    localparam int               HDR_BITS      = 17;
    localparam logic [CRC_W-1:0] CRC_POLY      = 15'h4599;
    localparam logic [2:0]       DELIM_PATTERN = 3'b101;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_FORM = 2'b01;
    localparam logic [1:0] ERR_CRC  = 2'b10;
    localparam logic [1:0] ERR_BUS  = 2'b11;

    // One serial step of the CAN CRC-15 (MSB-first, feedback from bit 14).
    function automatic logic [CRC_W-1:0] crc15_step(input logic [CRC_W-1:0] crc,
                                                    input logic             bit_in);
        logic fb;
        fb = bit_in ^ crc[14];
        crc15_step = {crc[13:0], 1'b0} ^ (fb ? CRC_POLY : 15'h0000);
    endfunction

endpackage

// File: rtl/can_frame_rx_if.sv
// Consumer-side interface of the CAN frame receiver: held frame with
// valid/ack handshake plus error/overrun/busy status.
interface can_frame_rx_if;
    import can_pkg::*;

    logic              rx_ack;
    logic              rx_valid;
    logic [ID_W-1:0]   rx_id;
    logic [CTRL_W-1:0] rx_ctrl;
    logic [DLC_W-1:0]  rx_dlc;
    logic [63:0]       rx_data;
    logic [CRC_W-1:0]  rx_crc;
    logic              frame_err;
    logic [1:0]        err_code;
    logic              overrun;
    logic              busy;

    modport master (
        input  rx_ack,
        output rx_valid, rx_id, rx_ctrl, rx_dlc, rx_data, rx_crc,
        output frame_err, err_code, overrun, busy
    );

    modport slave (
        output rx_ack,
        input  rx_valid, rx_id, rx_ctrl, rx_dlc, rx_data, rx_crc,
        input  frame_err, err_code, overrun, busy
    );

endinterface

// File: rtl/can_crc15.sv
// Serial CRC-15 accumulator with synchronous clear and enable.
module can_crc15
    import can_pkg::*;
(
    input  logic             can_clk,
    input  logic             nrst,
    input  logic             clr,
    input  logic             en,
    input  logic             bit_in,
    output logic [CRC_W-1:0] crc
);

    logic [CRC_W-1:0] crc_r;

    // Accumulate one bus bit per enabled cycle; clear has priority.
    always_ff @(posedge can_clk or negedge nrst) begin
        if (!nrst) begin
            crc_r <= 15'h0000;
        end else if (clr) begin
            crc_r <= 15'h0000;
        end else if (en) begin
            crc_r <= crc15_step(crc_r, bit_in);
        end else begin
            crc_r <= crc_r;
        end
    end

    assign crc = crc_r;

endmodule

// File: rtl/can_frame_rx.sv
// CAN standard-frame receiver: samples the differential pair once per
// can_clk, parses SOF/ID/ctrl/DLC/data/CRC/delimiters/EOF and hands the frame
// to a consumer through a valid/ack holding register.
// Optional build macro CAN_CRC_CHECK_EN enables CRC-15 verification of the
// received frame; without it the CRC field is only captured.
module can_frame_rx
    import can_pkg::*;
#(
    parameter int EOF_LEN   = 7,
    parameter int MAX_BYTES = 8
) (
    input  logic           can_clk,
    input  logic           nrst,
    input  logic           can_hi_in,
    input  logic           can_lo_in,
    can_frame_rx_if.master rx_if
);

    localparam int                CNT_W    = $clog2(EOF_LEN + 1);
    localparam logic [CNT_W-1:0]  LAST_REC = CNT_W'(EOF_LEN - 1);
    localparam logic [DLC_W-1:0]  MAX_DLC  = DLC_W'(MAX_BYTES);

    logic                hi_r, lo_r;
    can_state_t          state_r;
    logic [CNT_W-1:0]    rec_cnt_r;
    logic [6:0]          bit_cnt_r;
    logic [6:0]          data_bits_r;
    logic [HDR_BITS-1:0] hdr_sh_r;
    logic [CRC_W-1:0]    crc_sh_r;
    logic [63:0]         data_r;

    logic              rx_valid_r;
    logic [ID_W-1:0]   rx_id_r;
    logic [CTRL_W-1:0] rx_ctrl_r;
    logic [DLC_W-1:0]  rx_dlc_r;
    logic [63:0]       rx_data_r;
    logic [CRC_W-1:0]  rx_crc_r;
    logic              frame_err_r;
    logic [1:0]        err_code_r;
    logic              overrun_r;
    logic              busy_r;

    // Recessive (lo high) is logic 1; equal hi/lo is an invalid pair.
    logic             bit_s;
    logic             pair_ok_s;
    logic [DLC_W-1:0] dlc_s;
    logic [DLC_W-1:0] dlc_cl_s;
    logic [CRC_W-1:0] crc_rx_s;
    logic             crc_bad_s;

    assign bit_s     = lo_r;
    assign pair_ok_s = hi_r ^ lo_r;
    assign dlc_s     = {hdr_sh_r[2:0], bit_s};
    assign dlc_cl_s  = (dlc_s > MAX_DLC) ? MAX_DLC : dlc_s;
    assign crc_rx_s  = {crc_sh_r[13:0], bit_s};

`ifdef CAN_CRC_CHECK_EN
    logic             crc_en_s;
    logic             crc_clr_s;
    logic [CRC_W-1:0] crc_calc_s;

    // CRC covers SOF through the last data bit; the CRC state freezes it.
    assign crc_en_s  = pair_ok_s && (((state_r == ST_IDLE) && !bit_s) ||
                                     (state_r == ST_HDR) || (state_r == ST_DATA));
    assign crc_clr_s = (state_r == ST_INTEG) || (state_r == ST_DONE) ||
                       (state_r == ST_ERROR);
    assign crc_bad_s = (crc_calc_s != crc_rx_s);

    can_crc15 u_crc (
        .can_clk (can_clk),
        .nrst    (nrst),
        .clr     (crc_clr_s),
        .en      (crc_en_s),
        .bit_in  (bit_s),
        .crc     (crc_calc_s)
    );
`else
    assign crc_bad_s = 1'b0;
`endif

    // Input sampling, frame-parsing FSM and consumer holding register.
    always_ff @(posedge can_clk or negedge nrst) begin
        if (!nrst) begin
            hi_r        <= 1'b0;
            lo_r        <= 1'b0;
            state_r     <= ST_INTEG;
            rec_cnt_r   <= '0;
            bit_cnt_r   <= 7'd0;
            data_bits_r <= 7'd0;
            hdr_sh_r    <= 17'h00000;
            crc_sh_r    <= 15'h0000;
            data_r      <= 64'h0;
            rx_valid_r  <= 1'b0;
            rx_id_r     <= 11'h000;
            rx_ctrl_r   <= 2'b00;
            rx_dlc_r    <= 4'h0;
            rx_data_r   <= 64'h0;
            rx_crc_r    <= 15'h0000;
            frame_err_r <= 1'b0;
            err_code_r  <= ERR_NONE;
            overrun_r   <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            hi_r        <= can_hi_in;
            lo_r        <= can_lo_in;
            frame_err_r <= 1'b0;
            overrun_r   <= 1'b0;
            busy_r      <= 1'b1;
            if (rx_valid_r && rx_if.rx_ack) begin
                rx_valid_r <= 1'b0;
            end else begin
                rx_valid_r <= rx_valid_r;
            end

            case (state_r)
                ST_INTEG: begin
                    if (pair_ok_s && bit_s) begin
                        if (rec_cnt_r == LAST_REC) begin
                            rec_cnt_r <= '0;
                            state_r   <= ST_IDLE;
                            busy_r    <= 1'b0;
                        end else begin
                            rec_cnt_r <= rec_cnt_r + 1'b1;
                        end
                    end else begin
                        rec_cnt_r <= '0;
                    end
                end
                ST_IDLE: begin
                    if (pair_ok_s && !bit_s) begin
                        hdr_sh_r  <= 17'h00000;
                        crc_sh_r  <= 15'h0000;
                        data_r    <= 64'h0;
                        bit_cnt_r <= 7'd0;
                        state_r   <= ST_HDR;
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                ST_HDR: begin
                    if (!pair_ok_s) begin
                        frame_err_r <= 1'b1;
                        err_code_r  <= ERR_BUS;
                        state_r     <= ST_ERROR;
                    end else begin
                        hdr_sh_r <= {hdr_sh_r[HDR_BITS-2:0], bit_s};
                        if (bit_cnt_r == 7'(HDR_BITS - 1)) begin
                            bit_cnt_r   <= 7'd0;
                            data_bits_r <= {dlc_cl_s, 3'b000};
                            state_r     <= (dlc_cl_s != 4'h0) ? ST_DATA : ST_CRC;
                        end else begin
                            bit_cnt_r <= bit_cnt_r + 7'd1;
                        end
                    end
                end
                ST_DATA: begin
                    if (!pair_ok_s) begin
                        frame_err_r <= 1'b1;
                        err_code_r  <= ERR_BUS;
                        state_r     <= ST_ERROR;
                    end else begin
                        // byte index in bits [5:3], MSB-first within each byte
                        data_r[{bit_cnt_r[5:3], ~bit_cnt_r[2:0]}] <= bit_s;
                        if (bit_cnt_r == data_bits_r - 7'd1) begin
                            bit_cnt_r <= 7'd0;
                            state_r   <= ST_CRC;
                        end else begin
                            bit_cnt_r <= bit_cnt_r + 7'd1;
                        end
                    end
                end
                ST_CRC: begin
                    if (!pair_ok_s) begin
                        frame_err_r <= 1'b1;
                        err_code_r  <= ERR_BUS;
                        state_r     <= ST_ERROR;
                    end else begin
                        crc_sh_r <= crc_rx_s;
                        if (bit_cnt_r == 7'd14) begin
                            bit_cnt_r <= 7'd0;
                            if (crc_bad_s) begin
                                frame_err_r <= 1'b1;
                                err_code_r  <= ERR_CRC;
                                state_r     <= ST_ERROR;
                            end else begin
                                state_r <= ST_DELIM;
                            end
                        end else begin
                            bit_cnt_r <= bit_cnt_r + 7'd1;
                        end
                    end
                end
                ST_DELIM: begin
                    if (!pair_ok_s) begin
                        frame_err_r <= 1'b1;
                        err_code_r  <= ERR_BUS;
                        state_r     <= ST_ERROR;
                    end else if (bit_s != DELIM_PATTERN[2'd2 - bit_cnt_r[1:0]]) begin
                        frame_err_r <= 1'b1;
                        err_code_r  <= ERR_FORM;
                        state_r     <= ST_ERROR;
                    end else if (bit_cnt_r == 7'd2) begin
                        bit_cnt_r <= 7'd0;
                        state_r   <= ST_EOF;
                    end else begin
                        bit_cnt_r <= bit_cnt_r + 7'd1;
                    end
                end
                ST_EOF: begin
                    if (!pair_ok_s) begin
                        frame_err_r <= 1'b1;
                        err_code_r  <= ERR_BUS;
                        state_r     <= ST_ERROR;
                    end else if (!bit_s) begin
                        frame_err_r <= 1'b1;
                        err_code_r  <= ERR_FORM;
                        state_r     <= ST_ERROR;
                    end else if (bit_cnt_r == 7'(EOF_LEN - 1)) begin
                        bit_cnt_r <= 7'd0;
                        state_r   <= ST_DONE;
                    end else begin
                        bit_cnt_r <= bit_cnt_r + 7'd1;
                    end
                end
                ST_DONE: begin
                    // An ack in the commit cycle frees the slot for the new frame.
                    if (!rx_valid_r || rx_if.rx_ack) begin
                        rx_valid_r <= 1'b1;
                        rx_id_r    <= hdr_sh_r[16:6];
                        rx_ctrl_r  <= hdr_sh_r[5:4];
                        rx_dlc_r   <= hdr_sh_r[3:0];
                        rx_data_r  <= data_r;
                        rx_crc_r   <= crc_sh_r;
                    end else begin
                        overrun_r <= 1'b1;
                    end
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
                ST_ERROR: begin
                    rec_cnt_r <= '0;
                    state_r   <= ST_INTEG;
                end
                default: begin
                    rec_cnt_r <= '0;
                    state_r   <= ST_INTEG;
                end
            endcase
        end
    end

    assign rx_if.rx_valid  = rx_valid_r;
    assign rx_if.rx_id     = rx_id_r;
    assign rx_if.rx_ctrl   = rx_ctrl_r;
    assign rx_if.rx_dlc    = rx_dlc_r;
    assign rx_if.rx_data   = rx_data_r;
    assign rx_if.rx_crc    = rx_crc_r;
    assign rx_if.frame_err = frame_err_r;
    assign rx_if.err_code  = err_code_r;
    assign rx_if.overrun   = overrun_r;
    assign rx_if.busy      = busy_r;

endmodule
